// File: rtl/fifo_pkg.sv
// Shared FIFO constants and pointer-width helper.
package fifo_pkg;
  localparam int DEPTH_DEF      = 8;
  localparam int DATA_WIDTH_DEF = 8;

  // Pointer carries one extra wrap bit above the storage address.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: synchronous write port, registered read port that resets to 0.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DEPTH-1:0][DATA_WIDTH-1:0] r_mem;
  logic [DATA_WIDTH-1:0]            r_rdata;

  // Storage is intentionally left unreset; stale words are unreachable once pointers clear.
  always_ff @(posedge wclk)
    if (i_we) r_mem[i_waddr] <= i_wdata;

  always_ff @(posedge wclk or negedge wrst)
    if (!wrst)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];

  assign o_rdata = r_rdata;
endmodule

// File: rtl/fifo_top.sv
// Single-clock FIFO: wrap-bit pointers, combinational flags/count, one fifo_mem.
module fifo_top
  import fifo_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  localparam int PW        = ptr_w(DEPTH),
  localparam int AW        = PW - 1
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic [PW-1:0]         count
);
  logic [PW-1:0] r_wptr, r_rptr;
  logic          w_wr_ok, w_rd_ok;

  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign count = r_wptr - r_rptr;

  assign w_wr_ok = w_en && !full;
  assign w_rd_ok = r_en && !empty;

  always_ff @(posedge wclk or negedge wrst)
    if (!wrst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
      if (w_rd_ok) r_rptr <= r_rptr + 1'b1;
    end

  fifo_mem #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_mem (
    .wclk    (wclk),
    .wrst    (wrst),
    .i_we    (w_wr_ok && wrst),
    .i_waddr (r_wptr[AW-1:0]),
    .i_wdata (data_in),
    .i_re    (w_rd_ok && wrst),
    .i_raddr (r_rptr[AW-1:0]),
    .o_rdata (data_out)
  );
endmodule

// File: tb/tb_fifo_top.sv
// Directed bench for fifo_top with a queue-based reference model and literal spot checks.
module tb_fifo_top;
  localparam int DEPTH = 8;
  localparam int DW    = 8;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic          wclk = 1'b0;
  logic          wrst = 1'b0;
  logic          w_en = 1'b0;
  logic          r_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          full, empty;
  logic [PW-1:0] count;

  int n_vec = 0;
  int n_err = 0;
  bit armed = 1'b0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] mdout = '0;

  fifo_top #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .wclk(wclk), .wrst(wrst), .w_en(w_en), .r_en(r_en),
    .data_in(data_in), .data_out(data_out),
    .full(full), .empty(empty), .count(count)
  );

  always #5 wclk = ~wclk;

  // Reference: occupancy is the queue length; reads pop before the write pushes.
  always @(posedge wclk or negedge wrst)
    if (!wrst) begin
      mq.delete();
      mdout <= '0;
    end else begin
      bit wok, rok;
      wok = w_en && (mq.size() < DEPTH);
      rok = r_en && (mq.size() > 0);
      if (rok) mdout <= mq.pop_front();
      if (wok) mq.push_back(data_in);
    end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge wclk)
    if (armed) begin
      chk("mdl_empty", int'(empty), int'(mq.size() == 0));
      chk("mdl_full",  int'(full),  int'(mq.size() == DEPTH));
      chk("mdl_count", int'(count), mq.size());
      chk("mdl_dout",  int'(data_out), int'(mdout));
    end

  task automatic cyc(input logic we, input logic re, input logic [DW-1:0] d);
    w_en = we; r_en = re; data_in = d;
    @(posedge wclk); #2;
    w_en = 1'b0; r_en = 1'b0;
  endtask

  task automatic lit(input string tag, input int e, input int f, input int c, input int d);
    chk({tag, "_empty"}, int'(empty), e);
    chk({tag, "_full"},  int'(full),  f);
    chk({tag, "_count"}, int'(count), c);
    chk({tag, "_dout"},  int'(data_out), d);
  endtask

  initial begin
    @(posedge wclk); #2;
    armed = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 8'hAA);
    lit("in_rst", 1, 0, 0, 0);
    wrst = 1'b1;
    lit("rst_rel", 1, 0, 0, 0);

    // First pass: 9 writes, the last dropped.
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, 1'b0, 8'h11 + 8'(i));
      if (i == 6) chk("p1_not_full_7", int'(full), 0);
      if (i == 7) lit("p1_full_8", 0, 1, 8, 0);
    end
    lit("p1_drop9", 0, 1, 8, 0);
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      chk("p1_rd", int'(data_out), (i < 8) ? 8'h11 + i : 8'h18);
      if (i == 6) chk("p1_not_empty_7", int'(empty), 0);
    end
    lit("p1_end", 1, 0, 0, 8'h18);

    // Second pass exercises the wrapped pointers.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 8'h21 + 8'(i));
      if (i == 6) chk("p2_not_full_7", int'(full), 0);
      if (i == 7) chk("p2_full_8", int'(full), 1);
    end
    lit("p2_full", 0, 1, 8, 8'h18);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      chk("p2_rd", int'(data_out), (i < 8) ? 8'h21 + i : 8'h28);
      if (i == 6) chk("p2_not_empty_7", int'(empty), 0);
    end
    lit("p2_end", 1, 0, 0, 8'h28);

    // Concurrent write/read at count=3 and while full.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h31 + 8'(i));
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 8'h34 + 8'(i));
      chk("sim_count", int'(count), 3);
      chk("sim_dout", int'(data_out), 8'h31 + i);
    end
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'h38 + 8'(i));
    lit("sim_fill", 0, 1, 8, 8'h34);
    cyc(1'b1, 1'b1, 8'hEE);
    lit("sim_full_wr", 0, 0, 7, 8'h35);

    // Simultaneous write/read while empty: only the write lands.
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 8'h00);
    lit("drain", 1, 0, 0, 8'h3C);
    cyc(1'b1, 1'b1, 8'h44);
    lit("emp_wr_rd", 0, 0, 1, 8'h3C);
    cyc(1'b0, 1'b1, 8'h00);
    chk("emp_wr_rd_val", int'(data_out), 8'h44);

    // Asynchronous reset with count=5, between clock edges.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'h51 + 8'(i));
    chk("pre_arst_count", int'(count), 5);
    #5 wrst = 1'b0;
    #1 lit("arst", 1, 0, 0, 0);
    @(posedge wclk); #2;
    wrst = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'h00);
    lit("post_arst_rd", 1, 0, 0, 0);
    cyc(1'b1, 1'b0, 8'h66);
    cyc(1'b0, 1'b1, 8'h00);
    lit("post_arst_wr", 1, 0, 0, 8'h66);

    @(negedge wclk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_top.md
FIFO_TOP -- requirements
Module: fifo_top

Interface
REQ-001 Parameter DEPTH, default 8, number of storage entries; SHALL be a power of two and at least 2.
REQ-002 Parameter DATA_WIDTH, default 8, bit width of each stored word.
REQ-003 wclk  input  1  the single clock; all state SHALL change on its rising edge only.
REQ-004 wrst  input  1  reset; asynchronous and active-low (0 = reset asserted).
REQ-005 w_en  input  1  write request, sampled at the wclk rising edge.
REQ-006 r_en  input  1  read request, sampled at the wclk rising edge.
REQ-007 data_in  input  DATA_WIDTH  write data, captured with an accepted write.
REQ-008 data_out  output  DATA_WIDTH  registered read data.
REQ-009 full  output  1  high when the FIFO holds DEPTH words.
REQ-010 empty  output  1  high when the FIFO holds 0 words.
REQ-011 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-012 Write accepted iff w_en=1 and full=0 at the edge; stores data_in at the write address and advances the write pointer by 1.
REQ-013 Read accepted iff r_en=1 and empty=0 at the edge; loads the word at the read address into data_out and advances the read pointer by 1.
REQ-014 Read latency: data_out SHALL show the oldest word one edge after the read is accepted, and SHALL hold its value when no read is accepted.
REQ-015 Ordering SHALL be strictly first-in first-out, with no loss or duplication of accepted words.
REQ-016 Pointers SHALL be $clog2(DEPTH)+1 bits wide: low bits address storage; the MSB is a wrap bit; pointers wrap modulo 2*DEPTH.
REQ-017 empty SHALL be 1 iff the write and read pointers are equal.
REQ-018 full SHALL be 1 iff the address bits are equal and the wrap bits differ.
REQ-019 count SHALL equal write pointer minus read pointer, computed modulo 2*DEPTH.
REQ-020 full, empty and count SHALL reflect the post-edge state combinationally from registered pointers; no extra latency.
REQ-021 A write while full SHALL be dropped silently: no pointer, memory or flag change.
REQ-022 A read while empty SHALL be ignored: data_out holds and the read pointer is unchanged.
REQ-023 Simultaneous write and read with 0<count<DEPTH SHALL both be accepted; count stays the same.
REQ-024 Simultaneous write and read while full: only the read is accepted; count becomes DEPTH-1.
REQ-025 Simultaneous write and read while empty: only the write is accepted; count becomes 1, and data_out is unchanged.
REQ-026 Wrap-around SHALL be seamless; behaviour SHALL be identical on every pass through the storage.

Reset
REQ-027 wrst=0 SHALL immediately, without waiting for wclk, clear both pointers to 0 and data_out to 0, giving empty=1, full=0, count=0.
REQ-028 Storage contents SHALL NOT be reset; old contents are unreachable after reset.
REQ-029 Reset asserted mid-operation SHALL discard all stored words.
REQ-030 While wrst=0, w_en and r_en SHALL be ignored.
REQ-031 The first accepted operation SHALL be on the first wclk rising edge with wrst=1.

Structure
REQ-032 Shared package fifo_pkg SHALL hold the default DEPTH and DATA_WIDTH constants and the pointer-width function ($clog2(DEPTH)+1).
REQ-033 One sub-module, fifo_mem: DEPTH x DATA_WIDTH array with a synchronous write port and a synchronous registered read port.
REQ-034 fifo_top SHALL contain the pointer registers, flag/count logic and accept gating, and one instance of fifo_mem.

Verification
REQ-035 Reset with wrst=0 for 5 edges, then release -> empty=1, full=0, count=0, data_out=0.
REQ-036 Nine consecutive writes of 0x11..0x19 (DEPTH=8) -> full=1 after the 8th; the 9th is dropped; count=8.
REQ-037 Nine consecutive reads after REQ-036 -> data_out sequence 0x11..0x18, each one edge after its accept; empty=1 after the 8th; the 9th read leaves data_out=0x18.
REQ-038 A second pass of 10 writes then 10 reads -> the wrapped pointers return 8 words in order; full and empty assert exactly as in the first pass.
REQ-039 At count=3, assert w_en and r_en together for 4 edges -> count stays 3 and output order is preserved; while full, the same stimulus -> count=7.
REQ-040 Assert wrst=0 asynchronously with count=5 -> empty=1 and count=0 immediately; subsequent reads return nothing until new writes.
